// File: rtl/pulse_logic_gate.sv
// Generic multi-input pulse gate.
//
// Data inputs and the evaluate input are toggle-encoded: every level change is one pulse.
// Pulses on the data inputs gather into a window. An evaluate pulse applies the selected rule
// (AND / OR / THRESH / XOR) to the gathered arrivals. When the rule holds and the window saw no
// duplicate arrival, out toggles DELAY cycles later. The gate also flags duplicate arrivals
// (err) and data pulses that land too soon after an evaluate (viol / viol_sticky).

module pulse_logic_gate #(
  parameter int unsigned N_IN        = 2,
  parameter int unsigned DELAY       = 3,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                mode,
  input  logic [$clog2(N_IN+1)-1:0] thresh,
  input  logic [N_IN-1:0]           in,
  input  logic                      eval,
  input  logic                      clr_err,
  output logic                      out,
  output logic                      fire,
  output logic [N_IN-1:0]           arrived,
  output logic                      err,
  output logic                      viol,
  output logic                      viol_sticky
);

  // Width of an arrival count; also the width of thresh.
  localparam int unsigned CW = $clog2(N_IN + 1);
  // Hold counter width; one bit is kept even when the hold check is disabled.
  localparam int unsigned HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  localparam logic [1:0] MODE_AND    = 2'd0;
  localparam logic [1:0] MODE_OR     = 2'd1;
  localparam logic [1:0] MODE_THRESH = 2'd2;
  localparam logic [1:0] MODE_XOR    = 2'd3;

  // Previous pin levels used for edge (pulse) detection.
  logic [N_IN-1:0]  in_q;
  logic             eval_q;
  // Cleared by reset. The first cycle after reset only captures the pin levels.
  logic             primed_q;

  // Window state.
  logic [N_IN-1:0]  arrived_q, arrived_d;
  logic             invalid_q, invalid_d;

  // Error and violation flags.
  logic             err_q, err_d;
  logic             viol_q, viol_d;
  logic             viol_sticky_q, viol_sticky_d;

  // Hold-window countdown.
  logic [HW-1:0]    hold_q, hold_d;

  // Delay line. Its last stage is the fire strobe.
  logic [DELAY-1:0] pipe_q, pipe_d;
  logic             out_q, out_d;

  // Combinational intermediates.
  logic [N_IN-1:0]  p_in;
  logic             p_ev;
  logic [N_IN-1:0]  dup;
  logic [CW-1:0]    cnt;
  logic             result;
  logic             inject;
  logic             hold_busy;

  // Number of set bits in an arrival vector.
  function automatic logic [CW-1:0] popcount(input logic [N_IN-1:0] v);
    logic [CW-1:0] acc;
    acc = '0;
    for (int i = 0; i < int'(N_IN); i++) begin
      acc = acc + CW'(v[i]);
    end
    return acc;
  endfunction

  // Pulse detection. All detection is suppressed until the pin levels have been captured once.
  always_comb begin
    p_in = '0;
    p_ev = 1'b0;
    if (primed_q) begin
      p_in = in ^ in_q;
      p_ev = eval ^ eval_q;
    end
  end

  // Rule evaluation on the window that closes with this evaluate.
  // Arrivals pulsing in the evaluate cycle belong to the next window, so they are not counted.
  always_comb begin
    cnt    = popcount(arrived_q);
    result = 1'b0;
    unique case (mode)
      MODE_AND:    result = (cnt == CW'(N_IN));
      MODE_OR:     result = (cnt != '0);
      MODE_THRESH: result = (cnt >= thresh);
      MODE_XOR:    result = cnt[0];
      default:     result = 1'b0;
    endcase
    inject = p_ev & result & ~invalid_q;
  end

  // Window bookkeeping. In an evaluate cycle the old window is discarded. Same-cycle arrivals
  // open the new window, so they can never be duplicates of the old one.
  always_comb begin
    dup       = '0;
    arrived_d = arrived_q;
    invalid_d = invalid_q;
    if (p_ev) begin
      arrived_d = p_in;
      invalid_d = 1'b0;
    end else begin
      dup       = p_in & arrived_q;
      arrived_d = arrived_q | p_in;
      invalid_d = invalid_q | (|dup);
    end
  end

  // Sticky duplicate-arrival error. A new duplicate in the same cycle beats clr_err.
  always_comb begin
    err_d = err_q;
    if (|dup) begin
      err_d = 1'b1;
    end else if (clr_err) begin
      err_d = 1'b0;
    end
  end

  // Hold window. The counter reloads on every evaluate and then counts down to zero.
  always_comb begin
    hold_busy = (hold_q != '0);
    hold_d    = hold_q;
    if (p_ev) begin
      hold_d = HW'(HOLD_CYCLES);
    end else if (hold_busy) begin
      hold_d = hold_q - HW'(1);
    end
  end

  // Hold violation: a data pulse in the evaluate cycle or while the window is still open.
  // The pulse is still accepted as an arrival.
  always_comb begin
    viol_d        = (HOLD_CYCLES != 0) && (|p_in) && (p_ev || hold_busy);
    viol_sticky_d = viol_sticky_q;
    if (viol_d) begin
      viol_sticky_d = 1'b1;
    end else if (clr_err) begin
      viol_sticky_d = 1'b0;
    end
  end

  // Delay line shift. With DELAY=1 the injected bit goes straight into the tail stage.
  if (DELAY == 1) begin : g_pipe_one
    assign pipe_d = inject;
  end else begin : g_pipe_many
    assign pipe_d = {pipe_q[DELAY-2:0], inject};
  end

  // out flips on the same edge that loads a 1 into the tail stage, so fire and the new out
  // level become visible in the same cycle.
  always_comb begin
    out_d = out_q ^ pipe_d[DELAY-1];
  end

  // Pin capture and priming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q     <= '0;
      eval_q   <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      in_q     <= in;
      eval_q   <= eval;
      primed_q <= 1'b1;
    end
  end

  // Window, error and hold state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arrived_q     <= '0;
      invalid_q     <= 1'b0;
      err_q         <= 1'b0;
      viol_q        <= 1'b0;
      viol_sticky_q <= 1'b0;
      hold_q        <= '0;
    end else begin
      arrived_q     <= arrived_d;
      invalid_q     <= invalid_d;
      err_q         <= err_d;
      viol_q        <= viol_d;
      viol_sticky_q <= viol_sticky_d;
      hold_q        <= hold_d;
    end
  end

  // Output delay line. Reset drops any toggles still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '0;
      out_q  <= 1'b0;
    end else begin
      pipe_q <= pipe_d;
      out_q  <= out_d;
    end
  end

  assign out         = out_q;
  assign fire        = pipe_q[DELAY-1];
  assign arrived     = arrived_q;
  assign err         = err_q;
  assign viol        = viol_q;
  assign viol_sticky = viol_sticky_q;

endmodule

// File: tb/tb_pulse_logic_gate.sv
// Bench for pulse_logic_gate. Two instances (N_IN=2 and N_IN=4) share one stimulus bus.
// The stimulus is a directed vector table, a hand-written THRESH sequence and a randomized run.
// Every cycle, both instances are compared against an event-level reference model.

module tb_pulse_logic_gate;

  localparam int DELAY = 3;
  localparam int HOLD  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode;
  logic [2:0] thresh3;
  logic [3:0] in4;
  logic       ev;
  logic       clr;

  logic       out_a, fire_a, err_a, viol_a, vst_a;
  logic [1:0] arr_a;
  logic       out_b, fire_b, err_b, viol_b, vst_b;
  logic [3:0] arr_b;

  always #5 clk = ~clk;

  pulse_logic_gate #(.N_IN(2), .DELAY(DELAY), .HOLD_CYCLES(HOLD)) dut_a (
    .clk(clk), .rst_n(rst_n), .mode(mode), .thresh(thresh3[1:0]), .in(in4[1:0]), .eval(ev),
    .clr_err(clr), .out(out_a), .fire(fire_a), .arrived(arr_a), .err(err_a), .viol(viol_a),
    .viol_sticky(vst_a)
  );

  pulse_logic_gate #(.N_IN(4), .DELAY(DELAY), .HOLD_CYCLES(HOLD)) dut_b (
    .clk(clk), .rst_n(rst_n), .mode(mode), .thresh(thresh3), .in(in4), .eval(ev),
    .clr_err(clr), .out(out_b), .fire(fire_b), .arrived(arr_b), .err(err_b), .viol(viol_b),
    .viol_sticky(vst_b)
  );

  int checks   = 0;
  int failures = 0;
  int ecnt     = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: the window is a set of arrivals, and each scheduled toggle is an absolute
  // edge number kept in a queue.
  typedef struct {
    int k;
    int t;
  } pend_t;
  pend_t    pend[$];
  bit       m_primed[2];
  bit [3:0] m_prev_in[2];
  bit       m_prev_ev[2];
  bit [3:0] m_arr[2];
  bit       m_inval[2];
  bit       m_err[2], m_vst[2], m_viol[2], m_fire[2], m_out[2];
  bit       m_have_ev[2];
  int       m_last_ev[2];

  task automatic model_edge(input int k);
    bit [3:0] mask;
    bit [3:0] iv, pin, dup;
    bit       pev, res;
    int       n, cnt, th;
    pend_t    e;
    mask = (k == 0) ? 4'h3 : 4'hF;
    n    = (k == 0) ? 2 : 4;
    iv   = in4 & mask;
    th   = (k == 0) ? int'(thresh3[1:0]) : int'(thresh3);
    if (!rst_n) begin
      m_primed[k] = 0; m_arr[k] = 0; m_inval[k] = 0; m_err[k] = 0; m_vst[k] = 0;
      m_viol[k] = 0; m_fire[k] = 0; m_out[k] = 0; m_have_ev[k] = 0;
      for (int i = pend.size() - 1; i >= 0; i--) if (pend[i].k == k) pend.delete(i);
      return;
    end
    if (!m_primed[k]) begin
      pin = 0; pev = 0; m_primed[k] = 1;
    end else begin
      pin = iv ^ m_prev_in[k];
      pev = ev ^ m_prev_ev[k];
    end
    m_prev_in[k] = iv;
    m_prev_ev[k] = ev;
    m_viol[k] = (HOLD > 0) && (pin != 0) &&
                (pev || (m_have_ev[k] && (ecnt - m_last_ev[k] <= HOLD)));
    dup = pev ? 4'h0 : (pin & m_arr[k]);
    if (pev) begin
      cnt = $countones(m_arr[k]);
      case (mode)
        2'd0:    res = (cnt == n);
        2'd1:    res = (cnt >= 1);
        2'd2:    res = (cnt >= th);
        default: res = (cnt % 2 == 1);
      endcase
      if (res && !m_inval[k]) begin
        e.k = k;
        e.t = ecnt + DELAY - 1;
        pend.push_back(e);
      end
      m_arr[k] = pin; m_inval[k] = 0; m_last_ev[k] = ecnt; m_have_ev[k] = 1;
    end else begin
      m_arr[k] = m_arr[k] | pin;
      if (dup != 0) m_inval[k] = 1;
    end
    if (dup != 0) m_err[k] = 1;
    else if (clr) m_err[k] = 0;
    if (m_viol[k]) m_vst[k] = 1;
    else if (clr) m_vst[k] = 0;
    m_fire[k] = 0;
    for (int i = pend.size() - 1; i >= 0; i--) begin
      if (pend[i].k == k && pend[i].t == ecnt) begin
        m_fire[k] = 1;
        pend.delete(i);
      end
    end
    m_out[k] = m_out[k] ^ m_fire[k];
  endtask

  task automatic check_inst(input string tag, input int k, input logic o, input logic f,
                            input logic [3:0] ar, input logic e, input logic v, input logic vs);
    check($sformatf("%s.out@%0d", tag, ecnt), o, m_out[k]);
    check($sformatf("%s.fire@%0d", tag, ecnt), f, m_fire[k]);
    check($sformatf("%s.arrived@%0d", tag, ecnt), ar, m_arr[k]);
    check($sformatf("%s.err@%0d", tag, ecnt), e, m_err[k]);
    check($sformatf("%s.viol@%0d", tag, ecnt), v, m_viol[k]);
    check($sformatf("%s.viol_sticky@%0d", tag, ecnt), vs, m_vst[k]);
  endtask

  // One clock: optional async-reset check, edge, model update, then compare just after the edge.
  task automatic run_cycle();
    if (!rst_n) begin
      #1;
      check("async_rst.a", {out_a, fire_a, arr_a, err_a, viol_a, vst_a}, 0);
      check("async_rst.b", {out_b, fire_b, arr_b, err_b, viol_b, vst_b}, 0);
    end
    @(posedge clk);
    ecnt++;
    model_edge(0);
    model_edge(1);
    #1;
    check_inst("a", 0, out_a, fire_a, {2'b00, arr_a}, err_a, viol_a, vst_a);
    check_inst("b", 1, out_b, fire_b, arr_b, err_b, viol_b, vst_b);
  endtask

  // Directed vectors for the N_IN=2 instance in AND mode; expectations were derived by hand.
  typedef struct {
    bit       rst;
    bit [1:0] in;
    bit       ev;
    bit       clr;
    bit       out;
    bit       fire;
    bit [1:0] arr;
    bit       err;
    bit       viol;
    bit       vst;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit r, input bit [1:0] i, input bit e, input bit c, input bit o,
                     input bit f, input bit [1:0] a, input bit er, input bit v, input bit vs);
    vec_t x;
    x.rst = r; x.in = i; x.ev = e; x.clr = c;
    x.out = o; x.fire = f; x.arr = a; x.err = er; x.viol = v; x.vst = vs;
    tbl.push_back(x);
  endtask

  initial begin
    rst_n = 1'b0; mode = 2'd0; thresh3 = 3'd0; in4 = 4'h0; ev = 1'b0; clr = 1'b0;

    //  rst in    ev clr | out fire arr   err viol vst
    add(0, 2'b00, 0, 0,   0,  0,  2'b00, 0,  0,  0);  // held in reset
    add(0, 2'b00, 0, 0,   0,  0,  2'b00, 0,  0,  0);
    add(1, 2'b00, 0, 0,   0,  0,  2'b00, 0,  0,  0);  // priming edge
    add(1, 2'b01, 0, 0,   0,  0,  2'b01, 0,  0,  0);  // in[0] arrives
    add(1, 2'b01, 0, 0,   0,  0,  2'b01, 0,  0,  0);
    add(1, 2'b11, 0, 0,   0,  0,  2'b11, 0,  0,  0);  // in[1] arrives
    add(1, 2'b11, 1, 0,   0,  0,  2'b00, 0,  0,  0);  // evaluate: AND true
    add(1, 2'b11, 1, 0,   0,  0,  2'b00, 0,  0,  0);
    add(1, 2'b11, 1, 0,   1,  1,  2'b00, 0,  0,  0);  // toggle after DELAY
    add(1, 2'b11, 1, 0,   1,  0,  2'b00, 0,  0,  0);
    add(1, 2'b10, 1, 0,   1,  0,  2'b01, 0,  0,  0);  // only in[0]
    add(1, 2'b10, 0, 0,   1,  0,  2'b00, 0,  0,  0);  // evaluate: AND false
    add(1, 2'b10, 0, 0,   1,  0,  2'b00, 0,  0,  0);
    add(1, 2'b10, 0, 0,   1,  0,  2'b00, 0,  0,  0);
    add(1, 2'b10, 0, 0,   1,  0,  2'b00, 0,  0,  0);  // no toggle
    add(1, 2'b00, 0, 0,   1,  0,  2'b10, 0,  0,  0);  // in[1]
    add(1, 2'b10, 0, 0,   1,  0,  2'b10, 1,  0,  0);  // duplicate in[1]
    add(1, 2'b11, 0, 0,   1,  0,  2'b11, 1,  0,  0);
    add(1, 2'b11, 1, 0,   1,  0,  2'b00, 1,  0,  0);  // evaluate invalid window
    add(1, 2'b11, 1, 0,   1,  0,  2'b00, 1,  0,  0);
    add(1, 2'b11, 1, 0,   1,  0,  2'b00, 1,  0,  0);  // no toggle
    add(1, 2'b10, 1, 0,   1,  0,  2'b01, 1,  0,  0);
    add(1, 2'b00, 1, 0,   1,  0,  2'b11, 1,  0,  0);
    add(1, 2'b00, 0, 0,   1,  0,  2'b00, 1,  0,  0);  // evaluate full window
    add(1, 2'b00, 0, 0,   1,  0,  2'b00, 1,  0,  0);
    add(1, 2'b00, 0, 0,   0,  1,  2'b00, 1,  0,  0);  // toggles back to 0
    add(1, 2'b00, 0, 1,   0,  0,  2'b00, 0,  0,  0);  // clr_err
    add(1, 2'b00, 1, 0,   0,  0,  2'b00, 0,  0,  0);  // evaluate
    add(1, 2'b01, 1, 0,   0,  0,  2'b01, 0,  1,  1);  // pulse 1 cycle after: viol
    add(1, 2'b01, 1, 0,   0,  0,  2'b01, 0,  0,  1);
    add(1, 2'b01, 1, 0,   0,  0,  2'b01, 0,  0,  1);
    add(1, 2'b11, 0, 0,   0,  0,  2'b10, 0,  1,  1);  // pulse with evaluate: new window
    add(1, 2'b11, 0, 1,   0,  0,  2'b10, 0,  0,  0);  // clr_err clears viol_sticky
    add(1, 2'b10, 0, 0,   0,  0,  2'b11, 0,  1,  1);  // last hold cycle
    add(1, 2'b10, 0, 0,   0,  0,  2'b11, 0,  0,  1);
    add(1, 2'b00, 0, 0,   0,  0,  2'b11, 1,  0,  1);  // duplicate after hold
    add(1, 2'b00, 1, 1,   0,  0,  2'b00, 0,  0,  0);  // evaluate + clr
    add(1, 2'b00, 1, 0,   0,  0,  2'b00, 0,  0,  0);
    add(1, 2'b00, 1, 0,   0,  0,  2'b00, 0,  0,  0);
    add(1, 2'b01, 1, 0,   0,  0,  2'b01, 0,  0,  0);
    add(1, 2'b11, 1, 0,   0,  0,  2'b11, 0,  0,  0);
    add(1, 2'b11, 0, 0,   0,  0,  2'b00, 0,  0,  0);  // evaluate: toggle in flight
    add(0, 2'b11, 0, 0,   0,  0,  2'b00, 0,  0,  0);  // reset drops it
    add(0, 2'b11, 0, 0,   0,  0,  2'b00, 0,  0,  0);
    add(1, 2'b11, 0, 0,   0,  0,  2'b00, 0,  0,  0);  // in=11 at priming: no pulse
    add(1, 2'b11, 0, 0,   0,  0,  2'b00, 0,  0,  0);

    foreach (tbl[r]) begin
      rst_n = tbl[r].rst; in4 = {2'b00, tbl[r].in}; ev = tbl[r].ev; clr = tbl[r].clr;
      run_cycle();
      check($sformatf("tbl%0d.out", r), out_a, tbl[r].out);
      check($sformatf("tbl%0d.fire", r), fire_a, tbl[r].fire);
      check($sformatf("tbl%0d.arrived", r), arr_a, tbl[r].arr);
      check($sformatf("tbl%0d.err", r), err_a, tbl[r].err);
      check($sformatf("tbl%0d.viol", r), viol_a, tbl[r].viol);
      check($sformatf("tbl%0d.viol_sticky", r), vst_a, tbl[r].vst);
    end

    // THRESH on the N_IN=4 instance. thresh=3 exceeds N_IN for the N_IN=2 instance.
    mode = 2'd2; thresh3 = 3'd3;
    in4 = 4'b0010; run_cycle();          // in[0]
    in4 = 4'b0110; run_cycle();          // in[2]
    in4 = 4'b1110; run_cycle();          // in[3]
    ev = 1'b1;     run_cycle();          // evaluate: 3 >= 3
    run_cycle();
    check("thr3.b.fire_early", fire_b, 1'b0);
    run_cycle();
    check("thr3.b.fire", fire_b, 1'b1);
    check("thr3.b.out", out_b, 1'b1);
    check("thr_over_n.a.fire", fire_a, 1'b0);
    in4 = 4'b1111; run_cycle();          // in[0]
    in4 = 4'b1011; run_cycle();          // in[2]
    ev = 1'b0;     run_cycle();          // evaluate: 2 < 3
    run_cycle();
    run_cycle();
    check("thr2.b.fire", fire_b, 1'b0);
    check("thr2.b.out", out_b, 1'b1);
    thresh3 = 3'd0;
    ev = 1'b1;     run_cycle();          // empty window, thresh=0 still fires
    run_cycle();
    run_cycle();
    check("thr0.a.fire", fire_a, 1'b1);
    check("thr0.b.fire", fire_b, 1'b1);
    check("thr0.b.out", out_b, 1'b0);

    // Randomized run checked against the model each cycle.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
      else if (!rst_n && $urandom_range(0, 1) == 1) rst_n = 1'b1;
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) in4[b] = ~in4[b];
      if ($urandom_range(0, 4) == 0) ev = ~ev;
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) thresh3 = 3'($urandom_range(0, 7));
      clr = ($urandom_range(0, 29) == 0);
      run_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
